alu_ctrl_seq: RTL
=================

// Module: alu_ctrl_seq
// PURPOSE
//  Parametrised successor of the single-cycle ALU control decoder. Decodes {ALUOp, funct3, funct7}
//  for full RV32I plus optional RV32M into an OP_W-bit operation code and unit select, registers
//  it behind a valid/ready handshake, and sequences multi-cycle MUL/DIV ops with a latency counter
//  and MDU start/kill strobes. Sits between decode and execute in the multi-cycle/pipelined core.
// PARAMETERS
//  OP_W     5   operation code width (>=5); legacy 4-bit codes zero-extended
//  M_EXT    1   1 = RV32M decoded; 0 = funct7==0000001 flagged illegal
//  MUL_LAT  4   cycles from accept to out_valid for MUL* (>=2)
//  DIV_LAT  33  cycles from accept to out_valid for DIV*/REM* (>=2)
//  CNT_W    6   counter width, must hold max(MUL_LAT,DIV_LAT)-1
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous squash of held/in-flight op
//  in_valid   in   1     decode fields valid
//  in_ready   out  1     block can accept
//  alu_op     in   2     00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
//  funct3     in   3     instruction funct3
//  funct7     in   7     instruction funct7 (R-type; bit5 used for SRAI on I-type)
//  out_valid  out  1     operation/unit_sel/illegal valid
//  out_ready  in   1     execute consumes
//  operation  out  OP_W  operation code
//  unit_sel   out  2     0 ALU, 1 MUL, 2 DIV
//  illegal    out  1     unsupported encoding
//  mdu_start  out  1     1-cycle pulse on accept of MUL/DIV op
//  mdu_kill   out  1     1-cycle pulse when flush hits BUSY
//  busy       out  1     state==BUSY
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all outputs 0 except in_ready (combinational, =1 after reset).
//  Codes: AND 00000, OR 00001, ADD 00010, SLL 00011, XOR 00100, SRL 00101, SUB 00110, SRA 00111,
//   SLT 01000, SLTU 01001; M ops {2'b10,funct3} (MUL 10000 .. REMU 10111).
//  alu_op 00 -> ADD. 01 -> funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU, 010/011 illegal.
//  10 -> funct7 0000000 base op by funct3; 0100000 only with funct3 000 (SUB)/101 (SRA);
//   0000001 -> M op if M_EXT; all else illegal. 11 -> funct3 000 ADD always (funct7 ignored);
//   001 SLL needs funct7==0; 101 SRL (funct7[5]=0) / SRA (funct7[5]=1); others base op.
//  Illegal: operation=ADD, unit_sel=0, illegal=1, handled as single-cycle; never pulses mdu_start.
//  in_ready = (state==IDLE) && (!out_valid || out_ready); accept = in_valid && in_ready.
//  FSM IDLE: accept ALU op -> outputs registered, out_valid=1 next cycle (latency 1), stay IDLE.
//   accept MUL/DIV -> mdu_start pulse same cycle, counter=LAT-2, state BUSY, out_valid=0.
//  BUSY: counter decrements; at 0 -> out_valid=1 next edge (exactly LAT cycles after accept),
//   state HOLD.
//  HOLD: outputs stable while out_valid && !out_ready; on out_ready -> IDLE (no back-to-back
//   accept in that cycle; M ops cost LAT+1 cycles min). ALU ops stream back-to-back in IDLE.
//  Backpressure: out_valid held and operation/unit_sel/illegal stable until out_ready.
//  flush (priority over all): out_valid->0, state->IDLE, counter->0; mdu_kill=1 iff state BUSY;
//   in_ready=0 in flush cycle (no accept).
//  Async reset mid-BUSY: immediate IDLE, no mdu_kill (MDU reset by same rst_n).
// STRUCTURE
//  alu_ctrl_pkg: OP_* code localparams, UNIT_ALU/MUL/DIV, state enum IDLE/BUSY/HOLD.
//  Sub-module alu_op_decode: pure combinational decode (fields -> operation, unit_sel, illegal);
//   alu_ctrl_seq holds FSM, counter, output register.
// TESTING
//  1 Legacy: alu_op=00 -> 00010; 01/funct3=000 -> 00110; 10/f7=0,f3=111 -> 00000; 10/f3=110 -> 00001; 10/f3=001 -> 00011.
//  2 Stream: 4 R-type ops back-to-back, out_ready=1 -> out_valid every cycle, 1-cycle latency, order kept.
//  3 MUL: f7=0000001,f3=000 accepted at t -> mdu_start at t, busy t+1..t+3, out_valid at t+4, op 10000, unit 1.
//  4 Backpressure: out_ready=0 for 3 cycles after out_valid -> outputs stable, in_ready=0; release -> IDLE.
//  5 Flush during DIV at cycle 10 -> mdu_kill pulse, out_valid stays 0, in_ready=1 next cycle.
//  6 Illegal: 10/f7=0100000,f3=111 and M_EXT=0 with f7=0000001 -> illegal=1, op 00010, no mdu_start.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared operation codes, execute-unit selects and sequencer state encodings
// for the ALU control decoder and its multi-cycle sequencer.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SLL  = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_MUL = 2'd1;
    localparam logic [1:0] UNIT_DIV = 2'd2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Base RV32I op selected by funct3 alone (funct7 qualifiers handled by the caller).
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational decode of {alu_op, funct3, funct7} into an operation
// code, execute unit and illegal flag. Illegal encodings decode as ALU ADD.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit M_EXT = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] operation,
    output logic [1:0] unit_sel,
    output logic       illegal
);

    always_comb begin
        operation = OP_ADD;
        unit_sel  = UNIT_ALU;
        illegal   = 1'b0;
        case (alu_op)
            2'b00: operation = OP_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: operation = OP_SUB;
                    3'b100, 3'b101: operation = OP_SLT;
                    3'b110, 3'b111: operation = OP_SLTU;
                    default:        illegal   = 1'b1;
                endcase
            end
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    operation = base_op(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    operation = OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    operation = OP_SRA;
                end else if (funct7 == 7'b0000001 && M_EXT) begin
                    // MUL/MULH* have funct3[2]=0, DIV/REM* have funct3[2]=1.
                    operation = {2'b10, funct3};
                    unit_sel  = funct3[2] ? UNIT_DIV : UNIT_MUL;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                case (funct3)
                    3'b000: operation = OP_ADD;
                    3'b001: begin
                        if (funct7 == 7'b0000000) operation = OP_SLL;
                        else                      illegal   = 1'b1;
                    end
                    3'b101:  operation = funct7[5] ? OP_SRA : OP_SRL;
                    default: operation = base_op(funct3);
                endcase
            end
        endcase
        if (illegal) begin
            operation = OP_ADD;
            unit_sel  = UNIT_ALU;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control stage: decodes fields, presents them behind valid/ready,
// and sequences multi-cycle MUL/DIV ops with a latency counter and MDU strobes.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter bit M_EXT   = 1'b1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] operation,
    output logic [1:0]      unit_sel,
    output logic            illegal,
    output logic            mdu_start,
    output logic            mdu_kill,
    output logic            busy
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       dec_op;
    logic [1:0]       dec_unit;
    logic             dec_illegal;
    logic             accept;
    logic             dec_is_mdu;

    alu_op_decode #(.M_EXT(M_EXT)) u_decode (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .operation (dec_op),
        .unit_sel  (dec_unit),
        .illegal   (dec_illegal)
    );

    // Handshake: a transfer happens on in_valid && in_ready (input side) and
    // out_valid && out_ready (output side); flush blocks acceptance that cycle.
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept     = in_valid && in_ready;
    assign dec_is_mdu = (dec_unit != UNIT_ALU);
    assign mdu_start  = accept && dec_is_mdu;
    assign mdu_kill   = flush && (state == BUSY);
    assign busy       = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            operation <= '0;
            unit_sel  <= UNIT_ALU;
            illegal   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        operation <= OP_W'(dec_op);
                        unit_sel  <= dec_unit;
                        illegal   <= dec_illegal;
                        if (dec_is_mdu) begin
                            // Counter reaches 0 one cycle before out_valid rises.
                            cnt       <= (dec_unit == UNIT_MUL) ? CNT_W'(MUL_LAT - 2)
                                                                : CNT_W'(DIV_LAT - 2);
                            state     <= BUSY;
                            out_valid <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
